sf_pattern_checker: RTL and testbench
=====================================

Name: sf_pattern_checker

Overview:
Read-side companion of the serial-flash tester's page-program path. It consumes the byte stream returned by the flash read command and compares each byte against the same start/increment pattern the tester wrote. It accumulates a mismatch count and captures the first failing address and data for the display/UART reporting path. It sits between the SPI flash read-data interface and the tester FSM, which starts it once per iteration.

Parameters:
PAGE_BYTES, 256, bytes per flash page
PAGES_PER_ITER, 4096, pages checked per start (131072 pages / 32 iterations)
ADDR_W, 32, byte-address width

Ports:
i_clk_40mhz  in  1  system clock
i_rstn_40mhz  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; begin a check run
i_abort  in  1  one-cycle pulse; cancel the run in progress
i_pattern_sel  in  2  0..3 selects pattern A..D
i_start_addr  in  ADDR_W  flash byte address of the first byte
i_rd_valid  in  1  read byte available
i_rd_data  in  8  read byte
o_rd_ready  out  1  checker accepts the byte
o_busy  out  1  run in progress
o_done  out  1  one-cycle pulse at run completion
o_pass  out  1  last completed run had zero mismatches
o_err_count  out  32  mismatches in the current/last run (saturating)
o_first_err_addr  out  ADDR_W  address of the first mismatch
o_first_err_exp  out  8  expected byte at the first mismatch
o_first_err_got  out  8  received byte at the first mismatch
o_bytes_checked  out  32  bytes accepted in the current/last run

Behaviour:
- Reset: state ST_IDLE. All outputs 0, including o_rd_ready, o_pass, all counts and all capture registers.
- Patterns (start, incr): A=(00,01), B=(08,07), C=(10,0F), D=(18,17). Expected byte n = start + n*incr mod 256, held in an 8-bit accumulator that is incremented by incr per accepted byte.
- Total bytes N = PAGE_BYTES*PAGES_PER_ITER. The pattern runs continuously across page boundaries and does not restart per page.
- States:
  - ST_IDLE: on i_start, latch pattern_sel and start_addr, clear counts/captures/o_pass, then go to ST_LOAD.
  - ST_LOAD: load accumulator = start and byte index = 0, then go to ST_CHECK. This state takes exactly one cycle.
  - ST_CHECK: o_rd_ready=1. A byte is accepted on the cycle where i_rd_valid & o_rd_ready.
    - On accept: compare the byte, increment index and o_bytes_checked, advance the accumulator.
    - On mismatch: o_err_count += 1, saturating at FFFF_FFFF.
    - On the first mismatch only: capture address = start_addr + index (ADDR_W wrap), the expected byte and the received byte.
    - When the accepted byte has index N-1, go to ST_DONE.
  - ST_DONE: o_done=1 for one cycle; o_pass = (o_err_count==0), including the final byte's result. Then go to ST_IDLE.
- o_busy=1 in ST_LOAD, ST_CHECK and ST_DONE.
- Latency: a mismatch is reflected in o_err_count one cycle after accept. o_done asserts one cycle after the last accept.
- i_start while busy: ignored.
- i_abort in ST_LOAD or ST_CHECK: go to ST_IDLE next cycle. No o_done, o_pass=0, counts frozen.
- i_abort and i_start in the same cycle while in ST_IDLE: start wins; abort is ignored in ST_IDLE.
- i_rd_valid while not in ST_CHECK: not accepted and not counted.
- Reset mid-run: immediate return to reset values; no o_done.
- Results hold until the next i_start.

Optional Feature:
SF_CHECKER_STOP_ON_ERR_EN
- Defined: the first mismatch ends the run early. Transition ST_CHECK to ST_DONE after that accept; o_done pulses, o_pass=0, o_err_count=1, o_bytes_checked = index+1.
- Undefined: the run always consumes all N bytes.

Decomposition:
- sf_tester_fsm_pkg gains the following:
  - t_checker_state enum {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE} (logic [1:0]).
  - fn_pattern_start(sel) and fn_pattern_incr(sel), built on the existing c_tester_pattern_* constants so the writer and checker cannot diverge.
- One sub-module, sf_pattern_gen: 8-bit accumulator with load/advance controls. It is reused by the tester's page-program byte source.

Test Plan:
- Pattern A, PAGES_PER_ITER=2 (N=512), stream 00,01,...,FF,00,...,FF with valid every cycle -> o_done one cycle after the 512th accept, o_pass=1, o_err_count=0, o_bytes_checked=512.
- Pattern B, start_addr=0010_0000, byte index 3 corrupted (expect 1D, send 1C) -> o_err_count=1, first_err_addr=0010_0003, exp=1D, got=1C, o_pass=0.
- Pattern C with i_rd_valid toggling 1-0-1-0 -> still 512 accepts, o_pass=1, no byte counted while valid=0.
- Mismatches at indices 5 and 300 -> o_err_count=2; captures reflect index 5 only.
- i_abort after 100 accepts -> ST_IDLE next cycle, no o_done, o_bytes_checked=100, o_pass=0. A following i_start runs cleanly.
- With SF_CHECKER_STOP_ON_ERR_EN: mismatch at index 7 -> o_done after that accept, o_bytes_checked=8, o_err_count=1. Reset asserted mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sf_tester_fsm_pkg.sv
// Shared definitions for the serial-flash tester: checker state encoding and
// the four write/read data patterns. The writer and the checker both derive
// their start/increment values from the same constants so they cannot drift.
package sf_tester_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } t_checker_state;

  localparam logic [7:0] c_tester_pattern_a_start = 8'h00;
  localparam logic [7:0] c_tester_pattern_a_incr  = 8'h01;
  localparam logic [7:0] c_tester_pattern_b_start = 8'h08;
  localparam logic [7:0] c_tester_pattern_b_incr  = 8'h07;
  localparam logic [7:0] c_tester_pattern_c_start = 8'h10;
  localparam logic [7:0] c_tester_pattern_c_incr  = 8'h0F;
  localparam logic [7:0] c_tester_pattern_d_start = 8'h18;
  localparam logic [7:0] c_tester_pattern_d_incr  = 8'h17;

  function automatic logic [7:0] fn_pattern_start(input logic [1:0] sel);
    logic [7:0] val;
    case (sel)
      2'd0:    val = c_tester_pattern_a_start;
      2'd1:    val = c_tester_pattern_b_start;
      2'd2:    val = c_tester_pattern_c_start;
      default: val = c_tester_pattern_d_start;
    endcase
    return val;
  endfunction

  function automatic logic [7:0] fn_pattern_incr(input logic [1:0] sel);
    logic [7:0] val;
    case (sel)
      2'd0:    val = c_tester_pattern_a_incr;
      2'd1:    val = c_tester_pattern_b_incr;
      2'd2:    val = c_tester_pattern_c_incr;
      default: val = c_tester_pattern_d_incr;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sf_pattern_gen.sv
// 8-bit pattern accumulator: load sets it to the pattern start value, advance
// adds the pattern increment (mod 256). Shared by the page-program byte source
// and the read-back checker.
module sf_pattern_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] start,
  input  logic [7:0] incr,
  output logic [7:0] value
);

  // Accumulator: load has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (load) begin
      value <= start;
    end else if (advance) begin
      value <= value + incr;
    end
  end

endmodule

// File: rtl/sf_pattern_checker.sv
// Read-back checker for the serial-flash tester. Compares the flash read byte
// stream against the selected start/increment pattern, counts mismatches and
// captures the first failing address/expected/received byte.
// Optional build macro SF_CHECKER_STOP_ON_ERR_EN: end the run at the first
// mismatch instead of consuming the whole iteration.
module sf_pattern_checker
  import sf_tester_fsm_pkg::*;
#(
  parameter int PAGE_BYTES     = 256,
  parameter int PAGES_PER_ITER = 4096,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk_40mhz,
  input  logic              i_rstn_40mhz,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_pattern_sel,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_rd_valid,
  input  logic [7:0]        i_rd_data,
  output logic              o_rd_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [31:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [7:0]        o_first_err_exp,
  output logic [7:0]        o_first_err_got,
  output logic [31:0]       o_bytes_checked
);

  localparam logic [31:0] c_last_index = 32'(PAGE_BYTES * PAGES_PER_ITER - 1);

  t_checker_state    state;
  logic [1:0]        sel_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [31:0]       byte_index;
  logic [7:0]        exp_byte;
  logic              accept;
  logic              mismatch;
  logic              end_run;
  logic [31:0]       err_next;

  sf_pattern_gen u_pattern_gen (
    .clk     (i_clk_40mhz),
    .rst_n   (i_rstn_40mhz),
    .load    (state == ST_LOAD),
    .advance (accept),
    .start   (fn_pattern_start(sel_q)),
    .incr    (fn_pattern_incr(sel_q)),
    .value   (exp_byte)
  );

  // Accept/compare decode; an abort in the same cycle cancels the accept so
  // the counts freeze exactly where the abort found them
  always_comb begin
    accept   = (state == ST_CHECK) && o_rd_ready && i_rd_valid && !i_abort;
    mismatch = accept && (i_rd_data != exp_byte);
    err_next = (mismatch && (o_err_count != 32'hFFFF_FFFF)) ? o_err_count + 32'd1 : o_err_count;
`ifdef SF_CHECKER_STOP_ON_ERR_EN
    end_run  = accept && ((byte_index == c_last_index) || mismatch);
`else
    end_run  = accept && (byte_index == c_last_index);
`endif
  end

  // Run control FSM with registered status/result outputs
  always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
    if (!i_rstn_40mhz) begin
      state            <= ST_IDLE;
      sel_q            <= 2'd0;
      start_addr_q     <= '0;
      byte_index       <= 32'd0;
      o_rd_ready       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_count      <= 32'd0;
      o_first_err_addr <= '0;
      o_first_err_exp  <= 8'h00;
      o_first_err_got  <= 8'h00;
      o_bytes_checked  <= 32'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            sel_q            <= i_pattern_sel;
            start_addr_q     <= i_start_addr;
            o_pass           <= 1'b0;
            o_err_count      <= 32'd0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= 8'h00;
            o_first_err_got  <= 8'h00;
            o_bytes_checked  <= 32'd0;
            o_busy           <= 1'b1;
            state            <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            byte_index <= 32'd0;
            o_rd_ready <= 1'b1;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (i_abort) begin
            o_rd_ready <= 1'b0;
            o_busy     <= 1'b0;
            o_pass     <= 1'b0;
            state      <= ST_IDLE;
          end else if (accept) begin
            byte_index      <= byte_index + 32'd1;
            o_bytes_checked <= o_bytes_checked + 32'd1;
            o_err_count     <= err_next;
            if (mismatch && (o_err_count == 32'd0)) begin
              o_first_err_addr <= start_addr_q + ADDR_W'(byte_index);
              o_first_err_exp  <= exp_byte;
              o_first_err_got  <= i_rd_data;
            end
            if (end_run) begin
              o_rd_ready <= 1'b0;
              o_done     <= 1'b1;
              o_pass     <= (err_next == 32'd0);
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_rd_ready <= 1'b0;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sf_pattern_checker.sv
// Self-checking bench for sf_pattern_checker (N = 256 * 2 = 512 bytes per run).
// Expected run results are computed from an independent pattern table and
// pushed to a scoreboard queue when a stream is driven; they are popped and
// compared when the checker finishes (o_done) or is aborted/reset.
`timescale 1ns/1ps
module tb_sf_pattern_checker;

  localparam int c_total = 512;

  typedef struct packed {
    logic [31:0] errs;
    logic [31:0] addr;
    logic [7:0]  exp;
    logic [7:0]  got;
    logic [31:0] bytes;
    logic        pass;
  } t_result;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [1:0]  i_pattern_sel = 2'd0;
  logic [31:0] i_start_addr = 32'd0;
  logic        i_rd_valid = 1'b0;
  logic [7:0]  i_rd_data = 8'h00;
  logic        o_rd_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [31:0] o_err_count;
  logic [31:0] o_first_err_addr;
  logic [7:0]  o_first_err_exp;
  logic [7:0]  o_first_err_got;
  logic [31:0] o_bytes_checked;

  int assertCount = 0;
  int failCount = 0;
  t_result sb[$];
  logic [7:0] patStart [4];
  logic [7:0] patIncr  [4];

  sf_pattern_checker #(
    .PAGE_BYTES     (256),
    .PAGES_PER_ITER (2),
    .ADDR_W         (32)
  ) dut (
    .i_clk_40mhz      (clk),
    .i_rstn_40mhz     (rst_n),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_pattern_sel    (i_pattern_sel),
    .i_start_addr     (i_start_addr),
    .i_rd_valid       (i_rd_valid),
    .i_rd_data        (i_rd_data),
    .o_rd_ready       (o_rd_ready),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_err_count      (o_err_count),
    .o_first_err_addr (o_first_err_addr),
    .o_first_err_exp  (o_first_err_exp),
    .o_first_err_got  (o_first_err_got),
    .o_bytes_checked  (o_bytes_checked)
  );

  always #12.5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 32'(o_rd_ready), 32'd0);
    checkOutput({tag, "_busy"},  32'(o_busy), 32'd0);
    checkOutput({tag, "_done"},  32'(o_done), 32'd0);
    checkOutput({tag, "_pass"},  32'(o_pass), 32'd0);
    checkOutput({tag, "_errs"},  o_err_count, 32'd0);
    checkOutput({tag, "_faddr"}, o_first_err_addr, 32'd0);
    checkOutput({tag, "_fexp"},  32'(o_first_err_exp), 32'd0);
    checkOutput({tag, "_fgot"},  32'(o_first_err_got), 32'd0);
    checkOutput({tag, "_bytes"}, o_bytes_checked, 32'd0);
  endtask

  // Model the run, push its expected result, then drive the read stream.
  // Bytes listed in e1/e2 are sent one below the expected value.
  task automatic applyStimulus(input int sel, input logic [31:0] addr, input int e1, input int e2,
                               input bit toggle, input bit withAbort, input int limit);
    t_result r;
    logic [7:0] pexp;
    int n;
    bit started;
    bit drove;
    bit phase;
    bit fin;
    r = '0;
    r.bytes = 32'(limit);
    for (int k = 0; k < limit; k++) begin
      pexp = 8'(patStart[sel] + k * patIncr[sel]);
      if (k == e1 || k == e2) begin
        if (r.errs == 0) begin
          r.addr = addr + 32'(k);
          r.exp  = pexp;
          r.got  = pexp - 8'd1;
        end
        r.errs++;
`ifdef SF_CHECKER_STOP_ON_ERR_EN
        r.bytes = 32'(k + 1);
        break;
`endif
      end
    end
    r.pass = (limit == c_total) && (r.errs == 0);
    sb.push_back(r);

    @(negedge clk);
    i_start       = 1'b1;
    i_abort       = withAbort;
    i_pattern_sel = 2'(sel);
    i_start_addr  = addr;
    i_rd_valid    = 1'b1;
    i_rd_data     = 8'hA5;
    n = 0; started = 0; drove = 0; phase = 0; fin = 0;
    for (int cyc = 0; cyc < 4 * limit + 40; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      if (drove) n++;
      drove = 0;
      if (n == limit || (started && !o_rd_ready)) begin
        fin = 1;
        break;
      end
      if (o_rd_ready) begin
        started = 1;
        if (toggle && phase) begin
          i_rd_valid = 1'b0;
          i_rd_data  = 8'h5A;
          i_start    = (n == 200);
        end else begin
          pexp = 8'(patStart[sel] + n * patIncr[sel]);
          i_rd_valid = 1'b1;
          i_rd_data  = (n == e1 || n == e2) ? pexp - 8'd1 : pexp;
          drove = 1;
        end
        phase = !phase;
      end else begin
        i_rd_valid = 1'b1;
        i_rd_data  = 8'hA5;
      end
    end
    i_rd_valid = 1'b0;
    i_start    = 1'b0;
    checkOutput("stream_completed", 32'(fin), 32'd1);
  endtask

  // Completed run: o_done must already be high one cycle after the last accept
  task automatic finishRun(input string tag);
    t_result r;
    int waited;
    waited = 0;
    while (!o_done && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_done_latency"}, 32'(waited), 32'd0);
    r = sb.pop_front();
    checkOutput({tag, "_errs"},  o_err_count, r.errs);
    checkOutput({tag, "_faddr"}, o_first_err_addr, r.addr);
    checkOutput({tag, "_fexp"},  32'(o_first_err_exp), 32'(r.exp));
    checkOutput({tag, "_fgot"},  32'(o_first_err_got), 32'(r.got));
    checkOutput({tag, "_bytes"}, o_bytes_checked, r.bytes);
    checkOutput({tag, "_pass"},  32'(o_pass), 32'(r.pass));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_pass_hold"},  32'(o_pass), 32'(r.pass));
  endtask

  // Partial run (abort or reset pending): compare frozen counts
  task automatic checkPartial(input string tag);
    t_result r;
    r = sb.pop_front();
    checkOutput({tag, "_bytes"}, o_bytes_checked, r.bytes);
    checkOutput({tag, "_errs"},  o_err_count, r.errs);
    checkOutput({tag, "_pass"},  32'(o_pass), 32'(r.pass));
  endtask

  initial begin
    bit sawDone;
    patStart = '{8'h00, 8'h08, 8'h10, 8'h18};
    patIncr  = '{8'h01, 8'h07, 8'h0F, 8'h17};
    $display("[TB] sf_pattern_checker bench start");

    #30;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Read data offered while idle must not be counted
    i_rd_valid = 1'b1;
    i_rd_data  = 8'h33;
    repeat (3) @(negedge clk);
    i_rd_valid = 1'b0;
    checkOutput("idle_valid_bytes", o_bytes_checked, 32'd0);
    checkOutput("idle_valid_busy", 32'(o_busy), 32'd0);

    // Pattern A, clean, with abort coincident with start (start wins)
    applyStimulus(0, 32'h0000_0000, -1, -1, 0, 1, c_total);
    finishRun("patA_clean");

    // Pattern B, single corruption at index 3
    applyStimulus(1, 32'h0010_0000, 3, -1, 0, 0, c_total);
    finishRun("patB_err3");

    // Pattern C, valid toggling, stray start mid-run
    applyStimulus(2, 32'h0000_4000, -1, -1, 1, 0, c_total);
    finishRun("patC_toggle");

    // Pattern D, two mismatches, first capture wraps the address
    applyStimulus(3, 32'hFFFF_FFFE, 5, 300, 0, 0, c_total);
    finishRun("patD_two_err");

    // Abort after 100 accepts
    applyStimulus(1, 32'h0000_0100, -1, -1, 0, 0, 100);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    checkOutput("abort_ready", 32'(o_rd_ready), 32'd0);
    checkPartial("abort");
    sawDone = o_done;
    repeat (3) begin
      @(negedge clk);
      sawDone = sawDone | o_done;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    checkOutput("abort_bytes_hold", o_bytes_checked, 32'd100);

    applyStimulus(0, 32'h0000_0000, -1, -1, 0, 0, c_total);
    finishRun("after_abort");

    // Mismatch at index 7 (ends the run early when stop-on-error is built in)
    applyStimulus(2, 32'h0002_0000, 7, -1, 0, 0, c_total);
    finishRun("err7");

    // Reset asserted mid-run clears everything without a clock edge
    applyStimulus(3, 32'h0000_0800, -1, -1, 0, 0, 50);
    checkOutput("midrun_busy", 32'(o_busy), 32'd1);
    checkPartial("midrun");
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_done", 32'(o_done), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
